clk_div_sel: RTL and testbench
==============================

Name: clk_div_sel

Overview:
- Single-clock, enable-based successor to the ripple divider stage: one free-running counter produces every divide-by-2^k rate, and all logic runs on `clk`; there are no derived clocks.
- Produces three outputs at a runtime-selectable rate: a one-cycle `tick` strobe, a 50% square wave `clk_out`, and a duty-programmable `pwm_out`.
- Downstream blinkers and sequencers consume `tick` as a clock enable.
- Ratio changes go through a valid/ready handshake and take effect only at a period boundary, so outputs never glitch.

Parameters:
- CNT_W, 8, counter width; maximum division ratio is 2^CNT_W.
- SEL_W, 3, width of `div_sel`. Requires 2^SEL_W <= CNT_W.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  count enable; counter holds while low.
- div_sel  in  SEL_W  requested ratio; period P = 2^(div_sel+1), range 2..256.
- sel_valid  in  1  `div_sel` request valid.
- sel_ready  out  1  high when no change is pending; request accepted when `sel_valid & sel_ready`.
- duty  in  CNT_W  PWM duty as a fraction of 2^CNT_W.
- tick  out  1  one-cycle strobe per divided period.
- clk_out  out  1  divided square wave, 50% duty.
- pwm_out  out  1  PWM at the divided rate.

Behaviour:
- State registers:
  - `cnt` [CNT_W]
  - `sel_q` [SEL_W]: active ratio
  - `sel_pend` [SEL_W] and `pend` [1]: pending request
  - `duty_q` [CNT_W]: active duty
- Reset (synchronous, wins over everything):
  - `cnt`=0, `sel_q`=0 (divide by 2), `pend`=0, `duty_q`=0.
  - Outputs `tick`=0, `clk_out`=0, `pwm_out`=0, `sel_ready`=1, all in the cycle after reset is sampled.
- Counting:
  - When `en`=1, `cnt` increments modulo P, wrapping from P-1 to 0.
  - When `en`=0, `cnt` holds.
  - `wrap` = `en & (cnt == P-1)`.
- Outputs are registered, one cycle after the state they decode:
  - `tick` <= `wrap`, so `tick` is high in the cycle where `cnt` has just become 0.
  - `clk_out` <= `cnt[sel_q]`: low for the first half of the period, high for the second.
  - With `sel_q`=0, `clk_out` toggles every cycle while `en`=1.
  - `pwm_out` <= (`cnt` < `thr`), where `thr` = `duty_q` >> (CNT_W-1-`sel_q`).
  - `duty`=0 gives constant 0. `duty`=255 at P=256 gives 255 high cycles of 256.
- Duty:
  - `duty_q` loads from `duty` on every `wrap`, and on the first cycle after reset.
  - A mid-period duty change therefore never affects the current period.
- Handshake:
  - On `sel_valid & sel_ready`: `sel_pend` <= `div_sel`, `pend` <= 1, `sel_ready` falls the next cycle.
  - On `wrap` with `pend`=1: `sel_q` <= `sel_pend`, `cnt` <= 0, `pend` <= 0.
  - On `pend` with `en`=0: the change is applied immediately with `cnt` <= 0, because no period is in flight.
  - If acceptance and `wrap` fall in the same cycle, the new request is stored but applied at the next wrap, never the current one.
- Boundary cases:
  - Requesting the ratio already active still consumes one handshake and one wrap.
  - `en` dropping mid-period freezes all outputs at their current levels; `tick` deasserts.
  - Reset mid-period or mid-handshake discards the pending request.

Decomposition:
- Package `clk_div_pkg`:
  - CNT_W and SEL_W defaults.
  - A function returning P-1 for a given `sel`.
  - A function returning `thr` for a given (`duty`, `sel`).
- One natural sub-module, `clk_div_pwm_cmp`: registered comparator taking `cnt`, `duty_q` and `sel_q` and producing `pwm_out`.

Test Plan:
- Reset then `en`=1 with defaults -> `clk_out` toggles every cycle; `tick` every 2nd cycle; `pwm_out`=0 (`duty_q`=0); `sel_ready`=1.
- `div_sel`=3 handshake at cycle 5 with `en`=1 -> `sel_ready` low until the next wrap; afterwards P=16, `tick` every 16 cycles, `clk_out` 8 low / 8 high.
- P=16 with `duty`=0x40 -> `thr`=4, `pwm_out` high 4 cycles of 16. Change `duty` to 0xC0 mid-period -> current period still 4 high, next period 12 high.
- `div_sel`=7 with `duty`=255 -> 255 high / 1 low per 256 cycles. `duty`=0 -> `pwm_out` constantly 0.
- `en`=0 for 10 cycles mid-period -> `cnt` and all outputs frozen, no `tick`. A request made while `en`=0 is applied immediately, and `tick` comes P cycles after `en` rises.
- Assert reset with `pend`=1 at `cnt`=5 -> next cycle all outputs 0, `sel_q`=0, `sel_ready`=1; the pending request is never applied.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared sizing defaults and rate/duty helpers for the enable-based clock divider.
package clk_div_pkg;

  localparam int CNT_W_DEF = 8;
  localparam int SEL_W_DEF = 3;

  // Last counter value of a period, P-1 with P = 2^(sel+1).
  function automatic int unsigned period_last(input int unsigned sel);
    return (32'd2 << sel) - 32'd1;
  endfunction

  // Duty is a fraction of the full counter range; scale it down to the active period.
  function automatic int unsigned pwm_thr(input int unsigned duty, input int unsigned sel,
                                          input int unsigned cnt_w);
    return duty >> (cnt_w - 32'd1 - sel);
  endfunction

endpackage

// File: rtl/clk_div_pwm_cmp.sv
// Registered PWM comparator: high while the period counter is below the scaled duty threshold.
// Holds its level while counting is disabled.
module clk_div_pwm_cmp
  import clk_div_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [CNT_W-1:0] cnt,
  input  logic [CNT_W-1:0] duty_q,
  input  logic [SEL_W-1:0] sel_q,
  output logic             pwm_out
);

  logic [CNT_W-1:0] thr;

  assign thr = CNT_W'(pwm_thr(32'(duty_q), 32'(sel_q), CNT_W));

  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_out <= 1'b0;
    end else if (en) begin
      pwm_out <= (cnt < thr);
    end
  end

endmodule

// File: rtl/clk_div_sel.sv
// Single-clock divider: one counter yields tick, 50% square wave and PWM at a 2^(sel+1) rate.
// Ratio changes are handshaked and applied only at a period boundary (or at once while idle).
module clk_div_sel
  import clk_div_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [SEL_W-1:0] div_sel,
  input  logic             sel_valid,
  output logic             sel_ready,
  input  logic [CNT_W-1:0] duty,
  output logic             tick,
  output logic             clk_out,
  output logic             pwm_out
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] last;
  logic [CNT_W-1:0] duty_q;
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] sel_pend;
  logic             pend;
  logic             load_first;
  logic             wrap;
  logic             apply;
  logic             accept;

  assign last      = CNT_W'(period_last(32'(sel_q)));
  assign wrap      = en & (cnt == last);
  // With the counter stopped no period is in flight, so a pending ratio can land at once.
  assign apply     = pend & (wrap | ~en);
  assign sel_ready = ~pend;
  assign accept    = sel_valid & sel_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      sel_q      <= '0;
      sel_pend   <= '0;
      pend       <= 1'b0;
      duty_q     <= '0;
      load_first <= 1'b1;
      tick       <= 1'b0;
      clk_out    <= 1'b0;
    end else begin
      load_first <= 1'b0;
      if (wrap || load_first) duty_q <= duty;
      tick <= wrap;
      if (en) clk_out <= cnt[sel_q];
      if (apply) begin
        cnt   <= '0;
        sel_q <= sel_pend;
        pend  <= 1'b0;
      end else begin
        if (en) cnt <= wrap ? '0 : cnt + CNT_W'(1);
        if (accept) begin
          pend     <= 1'b1;
          sel_pend <= div_sel;
        end
      end
    end
  end

  clk_div_pwm_cmp #(
    .CNT_W(CNT_W),
    .SEL_W(SEL_W)
  ) u_pwm (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .cnt    (cnt),
    .duty_q (duty_q),
    .sel_q  (sel_q),
    .pwm_out(pwm_out)
  );

endmodule

// File: tb/tb_clk_div_sel.sv
// Directed bench for clk_div_sel: reset, rate change, PWM duty, enable freeze and reset abort.
module tb_clk_div_sel;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic [2:0] div_sel = '0;
  logic       sel_valid = 1'b0;
  logic       sel_ready;
  logic [7:0] duty = '0;
  logic       tick;
  logic       clk_out;
  logic       pwm_out;

  int n_chk = 0;
  int n_fail = 0;

  clk_div_sel dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .div_sel  (div_sel),
    .sel_valid(sel_valid),
    .sel_ready(sel_ready),
    .duty     (duty),
    .tick     (tick),
    .clk_out  (clk_out),
    .pwm_out  (pwm_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [7:0] d);
    reset = 1'b1; en = 1'b0; sel_valid = 1'b0; div_sel = '0; duty = d;
    step();
    reset = 1'b0;
  endtask

  // Request a ratio while stopped: accepted on the first edge, applied on the second.
  task automatic setup_sel(input logic [2:0] s);
    sel_valid = 1'b1; div_sel = s;
    step();
    sel_valid = 1'b0;
    step();
  endtask

  task automatic test_reset();
    logic e;
    do_reset(8'h00);
    n_chk++; if (tick !== 1'b0) begin n_fail++; $display("FAIL rst_tick got %b want 0", tick); end
    n_chk++; if (clk_out !== 1'b0) begin n_fail++; $display("FAIL rst_clk got %b want 0", clk_out); end
    n_chk++; if (pwm_out !== 1'b0) begin n_fail++; $display("FAIL rst_pwm got %b want 0", pwm_out); end
    n_chk++; if (sel_ready !== 1'b1) begin n_fail++; $display("FAIL rst_rdy got %b want 1", sel_ready); end
    en = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      step();
      e = (n % 2 == 0);
      n_chk++; if (tick !== e) begin n_fail++; $display("FAIL div2_tick n=%0d got %b want %b", n, tick, e); end
      n_chk++; if (clk_out !== e) begin n_fail++; $display("FAIL div2_clk n=%0d got %b want %b", n, clk_out, e); end
      n_chk++; if (pwm_out !== 1'b0) begin n_fail++; $display("FAIL div2_pwm n=%0d got %b want 0", n, pwm_out); end
      n_chk++; if (sel_ready !== 1'b1) begin n_fail++; $display("FAIL div2_rdy n=%0d got %b want 1", n, sel_ready); end
    end
  endtask

  task automatic test_handshake();
    logic et, ec;
    do_reset(8'h00);
    en = 1'b1;
    for (int n = 1; n <= 4; n++) step();
    sel_valid = 1'b1; div_sel = 3'd3;
    step();
    sel_valid = 1'b0;
    n_chk++; if (sel_ready !== 1'b0) begin n_fail++; $display("FAIL hs_rdy_low got %b want 0", sel_ready); end
    step();
    n_chk++; if (sel_ready !== 1'b1) begin n_fail++; $display("FAIL hs_rdy_high got %b want 1", sel_ready); end
    n_chk++; if (tick !== 1'b1) begin n_fail++; $display("FAIL hs_wrap_tick got %b want 1", tick); end
    for (int j = 0; j < 32; j++) begin
      step();
      et = (j % 16 == 15);
      ec = ((j % 16) >= 8);
      n_chk++; if (tick !== et) begin n_fail++; $display("FAIL p16_tick j=%0d got %b want %b", j, tick, et); end
      n_chk++; if (clk_out !== ec) begin n_fail++; $display("FAIL p16_clk j=%0d got %b want %b", j, clk_out, ec); end
    end
  endtask

  task automatic test_back_to_back();
    logic e;
    do_reset(8'h00);
    en = 1'b1;
    step();
    sel_valid = 1'b1; div_sel = 3'd2;
    step();
    sel_valid = 1'b0;
    n_chk++; if (tick !== 1'b1) begin n_fail++; $display("FAIL b2b_tick0 got %b want 1", tick); end
    n_chk++; if (sel_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_rdy0 got %b want 0", sel_ready); end
    step();
    n_chk++; if (sel_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_rdy1 got %b want 0", sel_ready); end
    n_chk++; if (tick !== 1'b0) begin n_fail++; $display("FAIL b2b_tick1 got %b want 0", tick); end
    step();
    n_chk++; if (sel_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_rdy2 got %b want 1", sel_ready); end
    n_chk++; if (tick !== 1'b1) begin n_fail++; $display("FAIL b2b_tick2 got %b want 1", tick); end
    for (int j = 0; j < 8; j++) begin
      step();
      e = (j == 7);
      n_chk++; if (tick !== e) begin n_fail++; $display("FAIL p8_tick j=%0d got %b want %b", j, tick, e); end
    end
    // Re-requesting the active ratio still waits for a full wrap.
    sel_valid = 1'b1; div_sel = 3'd2;
    step();
    sel_valid = 1'b0;
    n_chk++; if (sel_ready !== 1'b0) begin n_fail++; $display("FAIL same_rdy0 got %b want 0", sel_ready); end
    for (int k = 1; k <= 7; k++) begin
      step();
      e = (k == 7);
      n_chk++; if (sel_ready !== e) begin n_fail++; $display("FAIL same_rdy k=%0d got %b want %b", k, sel_ready, e); end
      n_chk++; if (tick !== e) begin n_fail++; $display("FAIL same_tick k=%0d got %b want %b", k, tick, e); end
    end
    for (int j = 0; j < 8; j++) begin
      step();
      e = (j == 7);
      n_chk++; if (tick !== e) begin n_fail++; $display("FAIL same_p8 j=%0d got %b want %b", j, tick, e); end
    end
  endtask

  task automatic test_pwm();
    logic ep, et;
    do_reset(8'h40);
    sel_valid = 1'b1; div_sel = 3'd3;
    step();
    sel_valid = 1'b0;
    n_chk++; if (sel_ready !== 1'b0) begin n_fail++; $display("FAIL idle_rdy0 got %b want 0", sel_ready); end
    step();
    n_chk++; if (sel_ready !== 1'b1) begin n_fail++; $display("FAIL idle_rdy1 got %b want 1", sel_ready); end
    en = 1'b1;
    for (int j = 0; j < 32; j++) begin
      step();
      ep = (j < 16) ? (j < 4) : ((j - 16) < 12);
      et = (j == 15) || (j == 31);
      n_chk++; if (pwm_out !== ep) begin n_fail++; $display("FAIL pwm16 j=%0d got %b want %b", j, pwm_out, ep); end
      n_chk++; if (tick !== et) begin n_fail++; $display("FAIL idle_tick j=%0d got %b want %b", j, tick, et); end
      if (j == 7) duty = 8'hC0;
    end
  endtask

  task automatic test_pwm_full();
    logic ep;
    int highs;
    do_reset(8'hFF);
    setup_sel(3'd7);
    en = 1'b1;
    highs = 0;
    for (int j = 0; j < 512; j++) begin
      step();
      ep = (j < 255);
      if (pwm_out === 1'b1) highs++;
      n_chk++; if (pwm_out !== ep) begin n_fail++; $display("FAIL pwm256 j=%0d got %b want %b", j, pwm_out, ep); end
      if (j == 128) duty = 8'h00;
    end
    n_chk++; if (highs !== 255) begin n_fail++; $display("FAIL pwm256_count got %0d want 255", highs); end
  endtask

  task automatic test_en_freeze();
    logic e;
    do_reset(8'hC0);
    setup_sel(3'd3);
    en = 1'b1;
    for (int j = 0; j < 10; j++) step();
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      n_chk++; if (tick !== 1'b0) begin n_fail++; $display("FAIL frz_tick k=%0d got %b want 0", k, tick); end
      n_chk++; if (clk_out !== 1'b1) begin n_fail++; $display("FAIL frz_clk k=%0d got %b want 1", k, clk_out); end
      n_chk++; if (pwm_out !== 1'b1) begin n_fail++; $display("FAIL frz_pwm k=%0d got %b want 1", k, pwm_out); end
    end
    en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      e = (k == 5);
      n_chk++; if (tick !== e) begin n_fail++; $display("FAIL res_tick k=%0d got %b want %b", k, tick, e); end
      e = (k <= 5);
      n_chk++; if (clk_out !== e) begin n_fail++; $display("FAIL res_clk k=%0d got %b want %b", k, clk_out, e); end
      e = (k <= 1) || (k >= 6);
      n_chk++; if (pwm_out !== e) begin n_fail++; $display("FAIL res_pwm k=%0d got %b want %b", k, pwm_out, e); end
    end
  endtask

  task automatic test_reset_mid();
    logic e;
    do_reset(8'hC0);
    setup_sel(3'd3);
    en = 1'b1;
    for (int j = 0; j < 4; j++) step();
    sel_valid = 1'b1; div_sel = 3'd1;
    step();
    sel_valid = 1'b0;
    n_chk++; if (sel_ready !== 1'b0) begin n_fail++; $display("FAIL mid_pend got %b want 0", sel_ready); end
    n_chk++; if (pwm_out !== 1'b1) begin n_fail++; $display("FAIL mid_pwm got %b want 1", pwm_out); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    duty = 8'h00;
    n_chk++; if (tick !== 1'b0) begin n_fail++; $display("FAIL mrst_tick got %b want 0", tick); end
    n_chk++; if (clk_out !== 1'b0) begin n_fail++; $display("FAIL mrst_clk got %b want 0", clk_out); end
    n_chk++; if (pwm_out !== 1'b0) begin n_fail++; $display("FAIL mrst_pwm got %b want 0", pwm_out); end
    n_chk++; if (sel_ready !== 1'b1) begin n_fail++; $display("FAIL mrst_rdy got %b want 1", sel_ready); end
    for (int n = 1; n <= 8; n++) begin
      step();
      e = (n % 2 == 0);
      n_chk++; if (tick !== e) begin n_fail++; $display("FAIL mrst_p2_tick n=%0d got %b want %b", n, tick, e); end
      n_chk++; if (clk_out !== e) begin n_fail++; $display("FAIL mrst_p2_clk n=%0d got %b want %b", n, clk_out, e); end
      n_chk++; if (sel_ready !== 1'b1) begin n_fail++; $display("FAIL mrst_p2_rdy n=%0d got %b want 1", n, sel_ready); end
      n_chk++; if (pwm_out !== 1'b0) begin n_fail++; $display("FAIL mrst_p2_pwm n=%0d got %b want 0", n, pwm_out); end
    end
  endtask

  initial begin
    test_reset();
    test_handshake();
    test_back_to_back();
    test_pwm();
    test_pwm_full();
    test_en_freeze();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
